// File: rtl/crc_frame_serializer_if.sv
// Byte-stream handshake into crc_frame_serializer: data, last marker, valid/ready.
interface crc_frame_serializer_if;
  logic [7:0] in_data;
  logic       in_last;
  logic       in_valid;
  logic       in_ready;

  modport master (output in_data, output in_last, output in_valid, input in_ready);
  modport slave  (input in_data, input in_last, input in_valid, output in_ready);
endinterface

// File: rtl/crc_frame_serializer.sv
// Byte FIFO + LSB-first serializer feeding a serial CRC-8 engine, gated on its Valid.
// Optional `CRC_TIMEOUT_EN adds a WAIT_CRC watchdog of TIMEOUT cycles.
module crc_frame_serializer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                        CLK,
  input  logic                        rst_n,
  crc_frame_serializer_if.slave       bus,
  input  logic                        crc_valid,
  output logic                        ser_data,
  output logic                        ser_active,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        err,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] SHIFT    = 2'd1;
  localparam logic [1:0] GAP      = 2'd2;
  localparam logic [1:0] WAIT_CRC = 2'd3;

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || TIMEOUT < 1) begin : g_bad_param
    $error("crc_frame_serializer: FIFO_DEPTH must be a power of 2 >= 2 and TIMEOUT >= 1");
  end

  logic [8:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt, last_cnt;
  logic [8:0]    head;
  logic          push, pop, start;

  logic [1:0]    state;
  logic [7:0]    sr;
  logic          sr_last;
  logic [2:0]    bitcnt;
  logic          seen_high;

  assign head         = mem[rptr];
  assign bus.in_ready = (cnt != CW'(FIFO_DEPTH));
  assign push         = bus.in_valid & bus.in_ready;
  assign fifo_count   = cnt;
  assign busy         = (state != IDLE);
  // A full FIFO with no frame end buffered starts in streaming mode.
  assign start        = (last_cnt != '0) || (cnt == CW'(FIFO_DEPTH));

  always_comb begin
    pop = 1'b0;
    case (state)
      IDLE:    pop = start;
      SHIFT:   pop = (bitcnt == 3'd7) && !sr_last && (cnt != '0);
      default: pop = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wptr] <= {bus.in_last, bus.in_data};
  end

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      wptr     <= '0;
      rptr     <= '0;
      cnt      <= '0;
      last_cnt <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      cnt      <= cnt + CW'(push) - CW'(pop);
      last_cnt <= last_cnt + CW'(push & bus.in_last) - CW'(pop & head[8]);
    end
  end

`ifdef CRC_TIMEOUT_EN
  localparam int WW = $clog2(TIMEOUT + 1);
  logic [WW-1:0] wd;
`endif

  always_ff @(posedge CLK) begin
    if (!rst_n) begin
      state      <= IDLE;
      sr         <= '0;
      sr_last    <= 1'b0;
      bitcnt     <= '0;
      seen_high  <= 1'b0;
      ser_data   <= 1'b0;
      ser_active <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
`ifdef CRC_TIMEOUT_EN
      wd         <= '0;
`endif
    end else begin
      frame_done <= 1'b0;
      err        <= 1'b0;
      case (state)
        IDLE: begin
          ser_active <= 1'b0;
          ser_data   <= 1'b0;
          if (start) begin
            sr      <= head[7:0];
            sr_last <= head[8];
            bitcnt  <= '0;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          ser_data   <= sr[bitcnt];
          ser_active <= 1'b1;
          bitcnt     <= bitcnt + 1'b1;
          if (bitcnt == 3'd7) begin
            if (sr_last) begin
              state <= GAP;
            end else if (cnt != '0) begin
              sr      <= head[7:0];
              sr_last <= head[8];
            end else begin
              // Underrun: cut the frame here; later bytes form a new frame.
              err   <= 1'b1;
              state <= GAP;
            end
          end
        end
        GAP: begin
          ser_active <= 1'b0;
          ser_data   <= 1'b0;
          seen_high  <= 1'b0;
          state      <= WAIT_CRC;
`ifdef CRC_TIMEOUT_EN
          wd         <= '0;
`endif
        end
        WAIT_CRC: begin
          if (crc_valid) begin
            seen_high <= 1'b1;
          end else if (seen_high) begin
            seen_high  <= 1'b0;
            frame_done <= 1'b1;
            state      <= IDLE;
          end
`ifdef CRC_TIMEOUT_EN
          wd <= wd + 1'b1;
          if (!crc_valid && seen_high) begin
            wd <= '0;
          end else if (!seen_high && wd == WW'(TIMEOUT - 1)) begin
            wd    <= '0;
            err   <= 1'b1;
            state <= IDLE;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/crc_frame_serializer.md
Name: crc_frame_serializer

Overview:
- Upstream feeder for the serial CRC-8 engine.
- Accepts bytes over a valid/ready interface into a small FIFO and shifts each frame out LSB-first, one bit per clock, on ser_data, with ser_active held high for the whole frame.
- Holds off the next frame until the CRC engine has finished emitting its checksum, signalled by its Valid output returned on crc_valid.

Parameters:
- FIFO_DEPTH, 4, byte FIFO entries; power of 2, minimum 2.
- TIMEOUT, 64, WAIT_CRC watchdog limit in cycles; used only with CRC_TIMEOUT_EN.

Ports:
- CLK  in  1  clock, rising edge.
- rst_n  in  1  synchronous active-low reset; one clock, sampled on the CLK rising edge.
- in_data  in  8  byte to serialize.
- in_last  in  1  marks in_data as the final byte of its frame.
- in_valid  in  1  in_data/in_last are valid.
- in_ready  out  1  FIFO can accept a byte; transfer occurs when in_valid & in_ready.
- crc_valid  in  1  Valid from the CRC engine.
- ser_data  out  1  serial bit to CRC engine DATA.
- ser_active  out  1  frame envelope to CRC engine Active.
- busy  out  1  FSM not in IDLE.
- frame_done  out  1  one-cycle pulse when the CRC engine completes a frame.
- err  out  1  one-cycle pulse on underrun or watchdog expiry.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset: on any CLK edge with rst_n=0, all of the following happen:
  - FIFO is flushed and the FSM goes to IDLE.
  - ser_data, ser_active, frame_done, err and busy are 0.
  - in_ready is 1 from the first cycle after reset.
  - Reset mid-frame truncates the frame. ser_active falls at that edge; no flush bits are sent.
- FIFO:
  - Entries are 9 bits: {last, data}.
  - in_ready = (fifo_count != FIFO_DEPTH), computed from registered state.
  - A push and a pop in the same cycle leave the count unchanged.
  - Pointers wrap modulo FIFO_DEPTH.
  - last_cnt tracks the number of buffered entries with last=1.
- FSM states: IDLE, SHIFT, GAP, WAIT_CRC.
- IDLE -> SHIFT when (last_cnt != 0) or (fifo_count == FIFO_DEPTH).
  - A full FIFO with no last byte starts in streaming mode.
  - The head byte is popped into shift register sr[7:0], and the bit counter resets to 0.
- SHIFT:
  - Each cycle ser_data <= sr[bit], ser_active <= 1, bit counter increments.
  - Outputs are registered; ser_active rises one cycle after leaving IDLE.
  - At bit 7, if the current byte's last=0 and the FIFO is non-empty, the next byte is popped seamlessly, so ser_active has no gap between bytes.
  - A frame of N bytes therefore holds ser_active high for exactly 8N consecutive cycles.
- SHIFT -> GAP at bit 7 of a byte with last=1.
- Underrun: at bit 7 of a byte with last=0 and the FIFO empty, the frame is terminated.
  - err pulses one cycle and the FSM goes to GAP.
  - Any later bytes up to the next last belong to a new frame.
- GAP: exactly one cycle with ser_active=0 and ser_data=0, then WAIT_CRC.
- WAIT_CRC:
  - Tracks a seen_high flag.
  - Goes to IDLE on the first cycle with crc_valid=0 after seen_high was set.
  - frame_done pulses in that same cycle.
  - ser_active stays 0 throughout.
- busy = (state != IDLE).
- in_ready is independent of FSM state; the FIFO can fill during SHIFT and WAIT_CRC.
- Simultaneous push of a last byte while in WAIT_CRC: the byte is buffered, and the frame starts the cycle after returning to IDLE.

Optional Feature:
- Macro: CRC_TIMEOUT_EN.
- Enabled:
  - A watchdog counter counts cycles in WAIT_CRC.
  - If seen_high is still 0 after TIMEOUT cycles, the FSM goes to IDLE, err pulses, and frame_done does not pulse.
  - The counter clears on leaving WAIT_CRC.
- Disabled:
  - No counter exists, and WAIT_CRC waits indefinitely for crc_valid.
  - err is driven only by underrun.

Test Plan:
- Push 0xA5 with last=1 -> ser_active high for 8 cycles; ser_data = 1,0,1,0,0,1,0,1; then GAP. A CRC model returns crc_valid for 9 cycles -> frame_done pulses one cycle after crc_valid falls; busy=0 next cycle.
- Push 0x01, then 0x80 with last=1 back-to-back -> ser_active high for 16 contiguous cycles; ser_data = 1,0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1.
- FIFO_DEPTH=4: push 4 bytes with last=0 and hold in_valid -> in_ready=0 when fifo_count=4; streaming starts. With no further push, ser_active is high for 32 cycles, err pulses at the end, and the FSM enters GAP.
- Assert rst_n=0 for one cycle at bit 3 of the first byte of a 2-byte frame -> at that edge ser_active=0, fifo_count=0, busy=0, in_ready=1; no frame_done.
- With CRC_TIMEOUT_EN, TIMEOUT=64, crc_valid tied 0: send a 1-byte frame -> err pulses exactly 64 cycles after entering WAIT_CRC, FSM returns to IDLE, no frame_done. Without the macro -> busy stays 1 for 1000 cycles.
- Push a 1-byte frame while a previous frame is in WAIT_CRC -> the new frame's ser_active rises 2 cycles after the frame_done pulse.
